// File: rtl/imem_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory load/fetch sequencer.
// The sequencer state and the idle test are shared by the top and any future siblings.
package imem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VEC_HI = 3'd2,
        ST_VEC_LO = 3'd3,
        ST_RUN    = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    // IDLE and HALT are the only states that accept load_start/run_start.
    function automatic logic is_parked(ctrl_state_t s);
        return (s == ST_IDLE) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/load_addr_counter.sv
// Write-address and word counter for a program load, with terminal-count detect
// and the sticky overflow flag raised when the image fills LOAD_DEPTH without ld_last.
module load_addr_counter #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] LOAD_BASE  = '0,
    parameter int                LOAD_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic              last,
    output logic [ADDR_W-1:0] waddr,
    output logic              done,
    output logic              load_ovf
);

    localparam int CNT_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             terminal;

    assign terminal = (cnt_q == CNT_W'(LOAD_DEPTH - 1));
    assign done     = accept && (last || terminal);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr    <= '0;
            cnt_q    <= '0;
            load_ovf <= 1'b0;
        end else if (clr) begin
            waddr    <= LOAD_BASE;
            cnt_q    <= '0;
            load_ovf <= 1'b0;
        end else if (accept) begin
            waddr <= waddr + ADDR_W'(1);
            cnt_q <= cnt_q + CNT_W'(1);
            if (terminal && !last) begin
                load_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_load_fetch_ctrl.sv
// Sequencer owning the instruction memory port: streams a program image in, fetches
// the 32-bit reset vector, then drives PC for fetch with stall, redirect and halt.
module imem_load_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] LOAD_BASE  = '0,
    parameter int                LOAD_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] VEC_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              busy,
    output logic              load_ovf
);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] instr_pc_d;
    logic              instr_valid_d;
    logic              load_clr;
    logic              load_done;

    assign mem_we    = (state_q == ST_LOAD) && ld_valid;
    assign mem_wdata = ld_data;
    assign busy      = !is_parked(state_q);

    load_addr_counter #(
        .ADDR_W     (ADDR_W),
        .LOAD_BASE  (LOAD_BASE),
        .LOAD_DEPTH (LOAD_DEPTH)
    ) u_load_addr_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (load_clr),
        .accept   (mem_we),
        .last     (ld_last),
        .waddr    (mem_waddr),
        .done     (load_done),
        .load_ovf (load_ovf)
    );

    // NOTE: every signal assigned here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr;
        instr_pc_d    = instr_pc;
        instr_valid_d = instr_valid;
        ld_ready      = 1'b0;
        load_clr      = 1'b0;
        mem_raddr     = pc_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    load_clr = 1'b1;
                end else if (run_start) begin
                    state_d = ST_VEC_HI;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (load_done) begin
                    state_d = ST_VEC_HI;
                end
            end
            ST_VEC_HI: begin
                mem_raddr                 = VEC_ADDR;
                pc_d[ADDR_W-1 -: DATA_W]  = mem_rdata;
                state_d                   = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                mem_raddr         = VEC_ADDR + ADDR_W'(1);
                pc_d[DATA_W-1:0]  = mem_rdata;
                state_d           = ST_RUN;
            end
            ST_RUN: begin
                // Halt beats redirect beats stall; a redirect leaves one bubble.
                if (halt_req) begin
                    state_d       = ST_HALT;
                    instr_valid_d = 1'b0;
                end else if (redirect) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d       = mem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= instr_valid_d;
        end
    end

endmodule
